tdm_frame_assembler: RTL and testbench
======================================

Name: tdm_frame_assembler

Overview:
- Consumer stage for the 2-bit round-robin `select` from the 4-state sequencer (S0→S1→S2→S3→S0).
- Each cycle, samples the channel addressed by `select` and writes it into the matching frame slot.
- Emits a registered 4-slot frame with a 1-cycle valid pulse once slots 0..3 have been captured in order.
- Checks the `select` sequence and flags any out-of-order step with a sticky error.

Parameters:
- W, 8, data width of each channel and of each frame slot.
- CNT_W, 8, width of the frame counter; the counter wraps modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rstN  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- en  input  1  sample enable; when low, the block holds all state.
- select  input  2  slot index from the upstream sequencer.
- ch0  input  W  channel 0 data.
- ch1  input  W  channel 1 data.
- ch2  input  W  channel 2 data.
- ch3  input  W  channel 3 data.
- clr_err  input  1  synchronous clear of `seq_err`.
- frame  output  4*W  last completed frame; slot0 in [W-1:0], slot3 in [4W-1:3W].
- frame_valid  output  1  single-cycle pulse when `frame` updates.
- seq_err  output  1  sticky sequence-error flag.
- frame_count  output  CNT_W  number of completed frames, wrapping.

Behaviour:
- Reset (`rstN` low, asynchronous): `frame`=0, `frame_valid`=0, `seq_err`=0, `frame_count`=0; internal slots=0; expected index=0; state=HUNT. Takes effect immediately, including mid-frame; any partial frame is discarded.
- `frame_valid` defaults to 0 every cycle; it is 1 only for the cycle described below.
- en=0: no capture, no state/expected change, no error check; `frame_valid` is 0.
- State HUNT (en=1):
  - select=0: slot0←ch0, expected←1, go to COLLECT.
  - Otherwise: stay in HUNT; no error is raised (this is normal alignment after reset or after an error).
- State COLLECT (en=1):
  - select==expected: slot[select]←ch[select]; expected←expected+1 (2-bit, wraps).
  - If select==3 on that capture:
    - Next cycle, `frame` = {ch3 captured, slot2, slot1, slot0}; the slot-3 value goes straight into `frame`.
    - `frame_valid`=1 for exactly that one cycle.
    - `frame_count` increments in the same cycle.
    - State stays COLLECT with expected=0, so back-to-back frames produce a valid pulse every 4 enabled cycles.
  - select!=expected: `seq_err`←1; the partial frame is discarded and `frame` is unchanged.
    - If select==0: treat it as a new frame start (slot0←ch0, expected←1, stay COLLECT).
    - Otherwise: go to HUNT.
- Latency: `frame_valid` is registered 1 cycle after the clock edge that samples select=3.
- `clr_err`:
  - Synchronous; clears `seq_err` on the next edge.
  - If a new sequence error is detected in the same cycle, error wins and `seq_err` stays 1.
  - `clr_err` is honoured regardless of `en`.
- `frame_count` wrap: 2^CNT_W−1 → 0 with no flag.
- Slots are written only on a valid capture; stale slot data never appears in `frame` because a frame completes only after a full in-order 0..3 run.
- `frame` holds its value until the next completion.

Test Plan:
- Reset, then en=1, select cycling 0,1,2,3 with ch0..ch3=0x11,0x22,0x33,0x44 (W=8) → one cycle after select=3: frame=0x44332211, frame_valid=1 for 1 cycle, frame_count=1, seq_err=0.
- Continuous cycling for 3 frames with changing channel data → frame_valid pulses exactly every 4 cycles; frame_count=3; each frame matches the data present at the cycles where its slot was sampled.
- Inject sequence 0,1,3 → seq_err=1 at the edge after select=3; frame unchanged; no frame_valid. Then 0,1,2,3 → a valid frame completes, seq_err still 1. Assert clr_err → seq_err=0 next cycle.
- Drop en low for 2 cycles between select=1 and select=2 (select still advancing) → no capture or error while en=0. Resume with select=2,3 → frame completes with the correct slot data, no error.
- Assert rstN low asynchronously after slots 0 and 1 are captured → all outputs 0 immediately. After release, select 2,3,0,1,2,3 → HUNT ignores 2,3 (no error); first frame_valid follows the second select=3.
- CNT_W=2: run 5 frames → frame_count sequence 1,2,3,0,1. Also assert clr_err in the same cycle as a mismatch → seq_err remains 1.

Source files
------------

// File: rtl/tdm_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tdm_frame_assembler
// Purpose  : Collects four TDM channels into a 4-slot frame. The slot index
//            comes from an upstream round-robin sequencer. A frame is emitted
//            only after slots 0..3 are captured in order. Any out-of-order
//            step sets a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_frame_assembler #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             en,
  input  logic [1:0]       select,
  input  logic [W-1:0]     ch0,
  input  logic [W-1:0]     ch1,
  input  logic [W-1:0]     ch2,
  input  logic [W-1:0]     ch3,
  input  logic             clr_err,
  output logic [4*W-1:0]   frame,
  output logic             frame_valid,
  output logic             seq_err,
  output logic [CNT_W-1:0] frame_count
);

  localparam logic [0:0] c_HUNT    = 1'b0;
  localparam logic [0:0] c_COLLECT = 1'b1;

  logic [0:0]       r_state;
  logic [1:0]       r_expected;
  logic [W-1:0]     r_slot0;
  logic [W-1:0]     r_slot1;
  logic [W-1:0]     r_slot2;
  logic [4*W-1:0]   r_frame;
  logic             r_frame_valid;
  logic             r_seq_err;
  logic [CNT_W-1:0] r_frame_count;

  logic w_collect;
  logic w_match;
  logic w_capture;
  logic w_seq_err;
  logic w_complete;

  // Decode this cycle's event: in-order capture, frame completion or sequence error
  always_comb begin
    w_collect  = (r_state == c_COLLECT);
    w_match    = (select == r_expected);
    w_capture  = en && w_collect && w_match;
    w_seq_err  = en && w_collect && !w_match;
    w_complete = w_capture && (select == 2'd3);
  end

  // Alignment state and the next slot index expected from the sequencer
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= c_HUNT;
      r_expected <= 2'd0;
    end else if (en) begin
      if (!w_collect) begin
        if (select == 2'd0) begin
          r_state    <= c_COLLECT;
          r_expected <= 2'd1;
        end
      end else if (w_match) begin
        r_expected <= r_expected + 2'd1;
      end else if (select == 2'd0) begin
        // An out-of-order zero is taken as the start of a fresh frame
        r_expected <= 2'd1;
      end else begin
        r_state    <= c_HUNT;
        r_expected <= 2'd0;
      end
    end
  end

  // Slot storage; slot 0 loads on every enabled select of 0 because each such
  // case begins a frame (alignment, in-order wrap or restart after a mismatch)
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_slot2 <= '0;
    end else begin
      if (en && (select == 2'd0)) r_slot0 <= ch0;
      if (w_capture && (select == 2'd1)) r_slot1 <= ch1;
      if (w_capture && (select == 2'd2)) r_slot2 <= ch2;
    end
  end

  // Frame output register, completion pulse and frame counter; slot 3 goes straight to the frame
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_valid <= 1'b0;
      if (w_complete) begin
        r_frame       <= {ch3, r_slot2, r_slot1, r_slot0};
        r_frame_valid <= 1'b1;
        r_frame_count <= r_frame_count + CNT_W'(1);
      end
    end
  end

  // Sticky sequence error; a new error outranks a simultaneous clear
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_seq_err <= 1'b0;
    end else if (w_seq_err) begin
      r_seq_err <= 1'b1;
    end else if (clr_err) begin
      r_seq_err <= 1'b0;
    end
  end

  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign seq_err     = r_seq_err;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_tdm_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_frame_assembler
// Purpose  : Self-checking bench for tdm_frame_assembler. It uses a vector
//            table, hand-written corner sequences and random stimulus. All
//            results are checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_frame_assembler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         en = 1'b0;
  logic         clr_err = 1'b0;
  logic [1:0]   select = 2'd0;
  logic [W-1:0] ch0 = '0;
  logic [W-1:0] ch1 = '0;
  logic [W-1:0] ch2 = '0;
  logic [W-1:0] ch3 = '0;

  logic [4*W-1:0] frame;
  logic           frame_valid;
  logic           seq_err;
  logic [7:0]     frame_count;

  logic [4*W-1:0] frame2;
  logic           frame_valid2;
  logic           seq_err2;
  logic [1:0]     frame_count2;

  int n_checks = 0;
  int n_errs   = 0;

  tdm_frame_assembler #(.W(W), .CNT_W(8)) dut (
    .clk(clk), .rstN(rstN), .en(en), .select(select),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .clr_err(clr_err),
    .frame(frame), .frame_valid(frame_valid), .seq_err(seq_err),
    .frame_count(frame_count)
  );

  // Narrow-counter instance sharing the same stimulus, for wrap checks
  tdm_frame_assembler #(.W(W), .CNT_W(2)) dut2 (
    .clk(clk), .rstN(rstN), .en(en), .select(select),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .clr_err(clr_err),
    .frame(frame2), .frame_valid(frame_valid2), .seq_err(seq_err2),
    .frame_count(frame_count2)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Tracks whether we are aligned and the in-order run of captured values so far.
  bit         m_aligned;
  logic [7:0] m_run[$];
  logic [31:0] m_frame;
  logic       m_valid;
  logic       m_err;
  int         m_cnt;

  task automatic model_reset();
    m_aligned = 1'b0;
    m_run.delete();
    m_frame = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic e, input logic [1:0] s,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input logic cl);
    logic [7:0] chv[4];
    bit newerr;
    chv[0] = a; chv[1] = b; chv[2] = c; chv[3] = d;
    newerr  = 1'b0;
    m_valid = 1'b0;
    if (e) begin
      if (!m_aligned) begin
        if (s == 2'd0) begin
          m_run.delete();
          m_run.push_back(a);
          m_aligned = 1'b1;
        end
      end else if (int'(s) == m_run.size()) begin
        m_run.push_back(chv[s]);
        if (m_run.size() == 4) begin
          m_frame = {m_run[3], m_run[2], m_run[1], m_run[0]};
          m_valid = 1'b1;
          m_cnt   = m_cnt + 1;
          m_run.delete();
        end
      end else begin
        newerr = 1'b1;
        m_run.delete();
        if (s == 2'd0) m_run.push_back(a);
        else m_aligned = 1'b0;
      end
    end
    if (newerr) m_err = 1'b1;
    else if (cl) m_err = 1'b0;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [7:0] c8;
    logic [1:0] c2;
    c8 = m_cnt[7:0];
    c2 = m_cnt[1:0];
    chk("model_frame", frame, m_frame);
    chk("model_valid", frame_valid, m_valid);
    chk("model_err", seq_err, m_err);
    chk("model_count", frame_count, c8);
    chk("model_count2", frame_count2, c2);
    chk("model_valid2", frame_valid2, m_valid);
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge
  task automatic cyc(input logic e, input logic [1:0] s,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic [7:0] d,
                     input logic cl);
    en = e; select = s; ch0 = a; ch1 = b; ch2 = c; ch3 = d; clr_err = cl;
    @(posedge clk);
    model_step(e, s, a, b, c, d, cl);
    #1;
    check_model();
  endtask

  // Mid-cycle asynchronous reset pulse spanning one clock edge
  task automatic async_reset(input string tag);
    #3 rstN = 1'b0;
    #1;
    model_reset();
    chk({tag, "_frame"}, frame, 32'h0);
    chk({tag, "_valid"}, frame_valid, 1'b0);
    chk({tag, "_err"}, seq_err, 1'b0);
    chk({tag, "_count"}, frame_count, 8'h0);
    chk({tag, "_count2"}, frame_count2, 2'd0);
    @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  function automatic logic [7:0] rnd8();
    return 8'($urandom);
  endfunction

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic [7:0]  c0, c1, c2, c3;
    logic        clr;
    logic [31:0] f;
    logic        v;
    logic        e;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d[4];
    logic [1:0] seqs;
    logic [1:0] exp_cnt2[5];
    logic [31:0] expf;

    tbl[0]  = '{1'b1, 2'd0, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 32'h0,        1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 2'd1, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 32'h0,        1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 2'd2, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 32'h0,        1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 32'h44332211, 1'b1, 1'b0, 8'd1};
    tbl[4]  = '{1'b0, 2'd0, 8'h99, 8'h99, 8'h99, 8'h99, 1'b0, 32'h44332211, 1'b0, 1'b0, 8'd1};
    tbl[5]  = '{1'b1, 2'd0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b0, 32'h44332211, 1'b0, 1'b0, 8'd1};
    tbl[6]  = '{1'b1, 2'd1, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b0, 32'h44332211, 1'b0, 1'b0, 8'd1};
    tbl[7]  = '{1'b1, 2'd3, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b0, 32'h44332211, 1'b0, 1'b1, 8'd1};
    tbl[8]  = '{1'b1, 2'd0, 8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 32'h44332211, 1'b0, 1'b1, 8'd1};
    tbl[9]  = '{1'b1, 2'd1, 8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 32'h44332211, 1'b0, 1'b1, 8'd1};
    tbl[10] = '{1'b1, 2'd2, 8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 32'h44332211, 1'b0, 1'b1, 8'd1};
    tbl[11] = '{1'b1, 2'd3, 8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 32'h88776655, 1'b1, 1'b1, 8'd2};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 32'h88776655, 1'b0, 1'b0, 8'd2};

    exp_cnt2[0] = 2'd1; exp_cnt2[1] = 2'd2; exp_cnt2[2] = 2'd3;
    exp_cnt2[3] = 2'd0; exp_cnt2[4] = 2'd1;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_frame", frame, 32'h0);
    chk("rst_valid", frame_valid, 1'b0);
    chk("rst_err", seq_err, 1'b0);
    chk("rst_count", frame_count, 8'h0);
    rstN = 1'b1;

    // Vector table: basic frame, en low hold, 0,1,3 error, recovery, clear
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].en, tbl[i].sel, tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c3, tbl[i].clr);
      chk($sformatf("tbl%0d_frame", i), frame, tbl[i].f);
      chk($sformatf("tbl%0d_valid", i), frame_valid, tbl[i].v);
      chk($sformatf("tbl%0d_err", i), seq_err, tbl[i].e);
      chk($sformatf("tbl%0d_count", i), frame_count, tbl[i].cnt);
    end

    // Three back-to-back frames with fresh data every cycle
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 2'(k % 4), rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
      chk($sformatf("b2b%0d_valid", k), frame_valid, (k % 4) == 3);
    end
    chk("b2b_count", frame_count, 8'd5);

    // en dropped between select 1 and 2 while the sequencer keeps advancing
    for (int k = 0; k < 4; k++) d[k] = rnd8();
    cyc(1'b1, 2'd0, d[0], rnd8(), rnd8(), rnd8(), 1'b0);
    cyc(1'b1, 2'd1, rnd8(), d[1], rnd8(), rnd8(), 1'b0);
    cyc(1'b0, 2'd2, rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
    cyc(1'b0, 2'd3, rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
    cyc(1'b1, 2'd2, rnd8(), rnd8(), d[2], rnd8(), 1'b0);
    chk("endrop_novalid", frame_valid, 1'b0);
    cyc(1'b1, 2'd3, rnd8(), rnd8(), rnd8(), d[3], 1'b0);
    expf = {d[3], d[2], d[1], d[0]};
    chk("endrop_frame", frame, expf);
    chk("endrop_valid", frame_valid, 1'b1);
    chk("endrop_err", seq_err, 1'b0);

    // Asynchronous reset mid-frame, then HUNT alignment
    cyc(1'b1, 2'd0, rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
    cyc(1'b1, 2'd1, rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
    async_reset("arst");
    cyc(1'b1, 2'd2, rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
    cyc(1'b1, 2'd3, rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
    chk("hunt_novalid", frame_valid, 1'b0);
    chk("hunt_noerr", seq_err, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 2'(k), rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
    chk("hunt_valid", frame_valid, 1'b1);
    chk("hunt_count", frame_count, 8'd1);

    // Narrow counter wrap over five frames
    async_reset("arst2");
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 4; k++) cyc(1'b1, 2'(k), rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
      chk($sformatf("wrap%0d_count2", f), frame_count2, exp_cnt2[f]);
    end

    // Clear coinciding with a new mismatch: error must stay set
    cyc(1'b1, 2'd0, rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
    cyc(1'b1, 2'd2, rnd8(), rnd8(), rnd8(), rnd8(), 1'b1);
    chk("clr_vs_err", seq_err, 1'b1);
    cyc(1'b0, 2'd3, rnd8(), rnd8(), rnd8(), rnd8(), 1'b1);
    chk("clr_en_low", seq_err, 1'b0);

    // Random traffic: mostly in-order selects, occasional glitches, gaps and clears
    seqs = 2'd0;
    for (int k = 0; k < 600; k++) begin
      logic [1:0] s;
      s = ($urandom_range(0, 9) < 8) ? seqs : 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 7) != 0, s, rnd8(), rnd8(), rnd8(), rnd8(),
          $urandom_range(0, 15) == 0);
      seqs = seqs + 2'd1;
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
